// File: rtl/rom_ram_scramble_ctrl.sv
// rom_ram_scramble_ctrl: copies the whole ROM image into RAM, bit-scrambling
// each byte, while driving the ROM/RAM chip-select, enable and address pins.
// Optional read-back verify pass is enabled by defining SCRAMBLE_VERIFY_EN.
module rom_ram_scramble_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             DONE,
  output logic [DEPTH:0]   ERR_CNT,
  output logic [DEPTH-1:0] ROM_ADDR,
  output logic             ROM_CS,
  output logic             ROM_OE,
  input  logic [WIDTH-1:0] ROM_DATA,
  output logic [DEPTH-1:0] RAM_ADDR,
  output logic             RAM_CS,
  output logic             RAM_OE,
  output logic             RAM_WE,
  output logic [WIDTH-1:0] RAM_WDATA,
  output logic             RAM_WDATA_OE,
  input  logic [WIDTH-1:0] RAM_RDATA
);

  // The bit permutation below only makes sense for byte-wide data.
  if (WIDTH != 8) begin : g_bad_width
    $error("rom_ram_scramble_ctrl: WIDTH must be 8");
  end

  localparam logic [DEPTH:0] LAST_WORD = (DEPTH+1)'(2**DEPTH - 1);

`ifdef SCRAMBLE_VERIFY_EN
  localparam logic [DEPTH:0] ERR_MAX = (DEPTH+1)'(2**DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_ROM_RD, S_LATCH, S_RAM_WR, S_NEXT,
    S_VFY_RD, S_VFY_CMP, S_VFY_NEXT, S_DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_ROM_RD, S_LATCH, S_RAM_WR, S_NEXT, S_DONE
  } state_t;
`endif

  // Byte scramble: interleaves the low and high nibbles, high nibble reversed.
  function automatic logic [WIDTH-1:0] scramble(input logic [WIDTH-1:0] d);
    return {d[0], d[7], d[1], d[6], d[2], d[5], d[3], d[4]};
  endfunction

  state_t           state_q, state_d;
  logic [DEPTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [DEPTH:0]   err_q, err_d;

  // Next-state, word counter, write-data latch and error counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          cnt_d   = '0;
          err_d   = '0;
          state_d = S_ROM_RD;
        end
      end
      S_ROM_RD: state_d = S_LATCH;
      S_LATCH: begin
        wdata_d = scramble(ROM_DATA);
        state_d = S_RAM_WR;
      end
      S_RAM_WR: state_d = S_NEXT;
      S_NEXT: begin
        if (cnt_q == LAST_WORD) begin
          cnt_d = '0;
`ifdef SCRAMBLE_VERIFY_EN
          state_d = S_VFY_RD;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ROM_RD;
        end
      end
`ifdef SCRAMBLE_VERIFY_EN
      S_VFY_RD: state_d = S_VFY_CMP;
      S_VFY_CMP: begin
        if ((RAM_RDATA != scramble(ROM_DATA)) && (err_q != ERR_MAX))
          err_d = err_q + 1'b1;
        state_d = S_VFY_NEXT;
      end
      S_VFY_NEXT: begin
        if (cnt_q == LAST_WORD) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_VFY_RD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition; counters and error count are frozen.
    if (ABORT) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Pin strobes decoded from the current state; ROM stays enabled through
  // LATCH (and both memories through VFY_CMP) since read data is combinational.
  always_comb begin
    ROM_CS       = 1'b1;
    ROM_OE       = 1'b0;
    ROM_ADDR     = '0;
    RAM_CS       = 1'b1;
    RAM_OE       = 1'b0;
    RAM_WE       = 1'b0;
    RAM_WDATA_OE = 1'b0;
    RAM_ADDR     = '0;
    BUSY         = 1'b1;
    DONE         = 1'b0;
    case (state_q)
      S_IDLE: BUSY = 1'b0;
      S_ROM_RD, S_LATCH: begin
        ROM_CS   = 1'b0;
        ROM_OE   = 1'b1;
        ROM_ADDR = cnt_q[DEPTH-1:0];
      end
      S_RAM_WR: begin
        RAM_CS       = 1'b0;
        RAM_WE       = 1'b1;
        RAM_WDATA_OE = 1'b1;
        RAM_ADDR     = cnt_q[DEPTH-1:0];
      end
`ifdef SCRAMBLE_VERIFY_EN
      S_VFY_RD, S_VFY_CMP: begin
        ROM_CS   = 1'b0;
        ROM_OE   = 1'b1;
        ROM_ADDR = cnt_q[DEPTH-1:0];
        RAM_CS   = 1'b0;
        RAM_OE   = 1'b1;
        RAM_ADDR = cnt_q[DEPTH-1:0];
      end
`endif
      S_DONE: begin
        BUSY = 1'b0;
        DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign RAM_WDATA = wdata_q;

`ifdef SCRAMBLE_VERIFY_EN
  assign ERR_CNT = err_q;
`else
  // Without the verify pass there is nothing to count and no read-back.
  logic unused_rdata;
  assign unused_rdata = ^{RAM_RDATA, err_q};
  assign ERR_CNT      = '0;
`endif

endmodule

// File: tb/tb_rom_ram_scramble_ctrl.sv
// Directed bench for rom_ram_scramble_ctrl with behavioural ROM/RAM models.
// Also builds with SCRAMBLE_VERIFY_EN to exercise the verify pass.
module tb_rom_ram_scramble_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
`ifdef SCRAMBLE_VERIFY_EN
  localparam int EXP_DONE = 225;
`else
  localparam int EXP_DONE = 129;
`endif

  logic             CLK = 1'b0;
  logic             RST_N, START, ABORT;
  logic             BUSY, DONE;
  logic [DEPTH:0]   ERR_CNT;
  logic [DEPTH-1:0] ROM_ADDR, RAM_ADDR;
  logic             ROM_CS, ROM_OE, RAM_CS, RAM_OE, RAM_WE, RAM_WDATA_OE;
  logic [WIDTH-1:0] ROM_DATA, RAM_WDATA, RAM_RDATA;

  logic [7:0] rom [32];
  logic [7:0] ram [32];
  logic       clr_ram, corrupt;

  int n_vec = 0;
  int n_miss = 0;
  int done_cyc, busy_cnt, busy_first, we_pulses, we_run_max, strobe_viol;

  rom_ram_scramble_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT),
    .ROM_ADDR(ROM_ADDR), .ROM_CS(ROM_CS), .ROM_OE(ROM_OE), .ROM_DATA(ROM_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_CS(RAM_CS), .RAM_OE(RAM_OE), .RAM_WE(RAM_WE),
    .RAM_WDATA(RAM_WDATA), .RAM_WDATA_OE(RAM_WDATA_OE), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  assign ROM_DATA  = (!ROM_CS && ROM_OE) ? rom[ROM_ADDR] : 8'h00;
  assign RAM_RDATA = (!RAM_CS && RAM_OE) ? ram[RAM_ADDR] : 8'h00;

  always @(posedge CLK) begin
    if (clr_ram) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'hEE;
    end else if (!RAM_CS && RAM_WE) begin
      ram[RAM_ADDR] <= RAM_WDATA ^ ((corrupt && RAM_ADDR == 5'd7) ? 8'h01 : 8'h00);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_ram();
    @(negedge CLK) clr_ram = 1'b1;
    @(negedge CLK) clr_ram = 1'b0;
  endtask

  // Pulse START and follow the run cycle by cycle until DONE or a 400-cycle bound.
  task automatic run_copy(input bit extra_starts);
    int we_run;
    done_cyc = 0; busy_cnt = 0; busy_first = 0; we_pulses = 0;
    we_run_max = 0; strobe_viol = 0; we_run = 0;
    @(negedge CLK) START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge CLK);
      if (BUSY) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = n;
      end
      if (RAM_WE) begin
        we_run++;
        if (we_run == 1) we_pulses++;
        if (we_run > we_run_max) we_run_max = we_run;
      end else begin
        we_run = 0;
      end
      if (RAM_WE && RAM_OE) strobe_viol++;
      if (RAM_WDATA_OE && !RAM_WE) strobe_viol++;
      START = extra_starts && (n == 10 || n == 60);
      if (DONE) begin
        done_cyc = n;
        break;
      end
    end
    START = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; clr_ram = 1'b0; corrupt = 1'b0;
    rom[0] = 8'h01; rom[1] = 8'h80; rom[2] = 8'h0F; rom[3] = 8'hF0; rom[4] = 8'hFF;
    for (int i = 5; i < 32; i++) rom[i] = 8'(i);

    // reset state
    #12;
    chk("rst_rom_cs", ROM_CS, 1);
    chk("rst_ram_cs", RAM_CS, 1);
    chk("rst_strobes", {ROM_OE, RAM_OE, RAM_WE, RAM_WDATA_OE}, 0);
    chk("rst_addr_data", {ROM_ADDR, RAM_ADDR, RAM_WDATA}, 0);
    chk("rst_busy_done", {BUSY, DONE}, 0);
    chk("rst_err", ERR_CNT, 0);
    @(negedge CLK) RST_N = 1'b1;
    clear_ram();

    // full copy with scrambling and strobe monitoring
    run_copy(1'b0);
    chk("t1_done_cyc", done_cyc, EXP_DONE);
    chk("t1_busy_first", busy_first, 1);
    chk("t1_busy_cnt", busy_cnt, EXP_DONE - 1);
    chk("t1_ram0", ram[0], 8'h80);
    chk("t1_ram1", ram[1], 8'h40);
    chk("t1_ram2", ram[2], 8'hAA);
    chk("t1_ram3", ram[3], 8'h55);
    chk("t1_ram4", ram[4], 8'hFF);
    chk("t1_ram13", ram[13], 8'h8A);
    chk("t1_ram31", ram[31], 8'hAB);
    chk("t2_we_pulses", we_pulses, 32);
    chk("t2_we_width", we_run_max, 1);
    chk("t2_strobe_viol", strobe_viol, 0);
    chk("t1_done_cs", {ROM_CS, RAM_CS, BUSY}, 3'b110);
    chk("t1_err", ERR_CNT, 0);
    @(negedge CLK);
    chk("t1_done_hold", DONE, 1);

    // abort during cycle 50 (LATCH of word 12)
    clear_ram();
    @(negedge CLK) START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (50) @(negedge CLK);
    chk("t3_busy_pre", BUSY, 1);
    ABORT = 1'b1;
    @(negedge CLK) ABORT = 1'b0;
    chk("t3_cs", {ROM_CS, RAM_CS}, 2'b11);
    chk("t3_we_done_busy", {RAM_WE, DONE, BUSY}, 0);
    chk("t3_err_hold", ERR_CNT, 0);
    repeat (3) @(negedge CLK);
    chk("t3_idle_stays", BUSY, 0);
    chk("t3_ram11", ram[11], 8'hA2);
    chk("t3_ram12", ram[12], 8'hEE);
    chk("t3_ram13", ram[13], 8'hEE);
    run_copy(1'b0);
    chk("t3_redo_done", done_cyc, EXP_DONE);
    chk("t3_redo_ram12", ram[12], 8'h0A);
    chk("t3_redo_ram13", ram[13], 8'h8A);

    // asynchronous reset mid-copy, in cycle 70
    @(negedge CLK) START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    repeat (70) @(negedge CLK);
    chk("t4_busy_pre", BUSY, 1);
    chk("t4_wdata_pre", RAM_WDATA, 8'h01);
    #2 RST_N = 1'b0;
    #1;
    chk("t4_busy", BUSY, 0);
    chk("t4_cs", {ROM_CS, RAM_CS}, 2'b11);
    chk("t4_strobes", {ROM_OE, RAM_OE, RAM_WE, RAM_WDATA_OE}, 0);
    chk("t4_addr_data", {ROM_ADDR, RAM_ADDR, RAM_WDATA}, 0);
    @(negedge CLK) RST_N = 1'b1;
    clear_ram();
    run_copy(1'b1);
    chk("t4_ignored_start", done_cyc, EXP_DONE);
    chk("t4_busy_cnt", busy_cnt, EXP_DONE - 1);
    chk("t4_ram0", ram[0], 8'h80);

`ifdef SCRAMBLE_VERIFY_EN
    // verify pass with one corrupted RAM word, then a clean run
    clear_ram();
    corrupt = 1'b1;
    run_copy(1'b0);
    corrupt = 1'b0;
    chk("t5_err_one", ERR_CNT, 1);
    chk("t5_done_cyc", done_cyc, 225);
    clear_ram();
    run_copy(1'b0);
    chk("t5_err_zero", ERR_CNT, 0);
`else
    chk("t5_err_tied", ERR_CNT, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
